case_conv_sequencer: RTL and testbench

- Upstream feeder and downstream capture stage around the combinational toUpper converter.
- Buffers incoming ASCII bytes in a small FIFO and drives each byte onto toUpper's input.
- Holds that input stable for SETTLE_CYCLES clocks so the combinational path settles, which sets the minimum inter-input delay in hardware.
- Registers toUpper's result into a valid/ready output slot and keeps running statistics.

---
 rtl/case_conv_pkg.sv | 15 +
 rtl/byte_fifo.sv | 59 +++++
 rtl/case_conv_sequencer.sv | 119 +++++++++++
 tb/tb_case_conv_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/case_conv_pkg.sv
// Shared types and ASCII constants for the case-conversion sequencer.
// No logic; used by the RTL and by the bench reference model.
// No flow control.
package case_conv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    localparam logic [7:0] ASCII_LOWER_A    = 8'd97;
    localparam logic [7:0] ASCII_LOWER_Z    = 8'd122;
    localparam logic [7:0] ASCII_CASE_DELTA = 8'd32;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, DEPTH entries (power of two), head shown combinationally.
// Latency: a pushed byte is visible on rdata one clock after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keep occupancy.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/case_conv_sequencer.sv
// Feeds queued ASCII bytes to an external toUpper block, holds each for SETTLE_CYCLES, captures the result.
// Latency: accept at E0 (empty, idle) -> pop at E1 -> out_valid at E1+SETTLE_CYCLES; one byte per SETTLE_CYCLES+1 clocks.
// Backpressure: no pop while the output slot is occupied; FIFO then fills and in_ready drops.
module case_conv_sequencer
    import case_conv_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       conv_in,
    input  logic [7:0]       conv_out,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] changed_count
);

    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t          state;
    state_t          next_state;
    logic [SC_W-1:0] settle_cnt;
    logic [7:0]      fifo_rdata;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            capture;
    logic            slot_free;

    // in_ready is forced low while reset is asserted, not just after it clears the FIFO.
    assign in_ready  = !fifo_full && !rst;
    assign push      = in_valid && in_ready;
    assign slot_free = !out_valid || out_ready;
    assign busy      = (state == SETTLE) || !fifo_empty;

    byte_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next state: launch a byte only when one is queued and the result has somewhere to go.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    pop        = 1'b1;
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    capture    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and settle countdown; conv_in only moves on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            conv_in    <= '0;
        end else begin
            state <= next_state;
            if (pop) begin
                conv_in    <= fifo_rdata;
                settle_cnt <= SC_W'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SC_W'(1);
            end
        end
    end

    // Output slot and statistics; a capture always wins over a consume on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data      <= '0;
            out_valid     <= 1'b0;
            char_count    <= '0;
            changed_count <= '0;
        end else begin
            if (capture) begin
                out_data   <= conv_out;
                out_valid  <= 1'b1;
                char_count <= char_count + CNT_W'(1);
                if (conv_out != conv_in) begin
                    changed_count <= changed_count + CNT_W'(1);
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_case_conv_sequencer.sv
// Bench for case_conv_sequencer with a behavioural toUpper stub and a queue-based reference model.
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
// Outputs are collected at the falling edge whenever out_valid && out_ready.
module tb_case_conv_sequencer;
    import case_conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, busy;
    logic [7:0]  conv_in, conv_out, out_data;
    logic [15:0] char_count, changed_count;

    logic        w4_in_ready, w4_out_valid, w4_busy;
    logic [7:0]  w4_conv_in, w4_conv_out, w4_out_data;
    logic [3:0]  w4_char_count, w4_changed_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         got_t[$];

    always #5 clk = ~clk;

    // External toUpper stand-in: clear bit 5 for 'a'..'z'.
    assign conv_out    = (conv_in >= "a" && conv_in <= "z") ? (conv_in & 8'hDF) : conv_in;
    assign w4_conv_out = (w4_conv_in >= "a" && w4_conv_in <= "z") ? (w4_conv_in & 8'hDF) : w4_conv_in;

    case_conv_sequencer #(.DEPTH(4), .SETTLE_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .conv_in(conv_in), .conv_out(conv_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .char_count(char_count), .changed_count(changed_count)
    );

    case_conv_sequencer #(.DEPTH(4), .SETTLE_CYCLES(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(w4_in_ready),
        .conv_in(w4_conv_in), .conv_out(w4_conv_out), .out_data(w4_out_data), .out_valid(w4_out_valid),
        .out_ready(out_ready), .busy(w4_busy), .char_count(w4_char_count), .changed_count(w4_changed_count)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_t.push_back(cyc);
        end
    end

    function automatic logic [7:0] ref_upper(input logic [7:0] b);
        if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z) return b - ASCII_CASE_DELTA;
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        got_t.delete();
        rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic ok;
        int n;
        ok = 1'b0;
        n = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_timeout: byte %0d not accepted after %0d cycles", b, n);
        end
    endtask

    task automatic wait_outputs(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL output_count: got %0d outputs, expected %0d", got_q.size(), n);
        end
    endtask

    task automatic check_stream(input string name, input logic [7:0] vec[$]);
        int chg;
        chg = 0;
        for (int i = 0; i < vec.size(); i++) begin
            if (ref_upper(vec[i]) != vec[i]) chg++;
            checks++;
            if (i >= got_q.size()) begin
                errors++;
                $display("FAIL %s[%0d]: missing output, expected %0d", name, i, ref_upper(vec[i]));
            end else if (got_q[i] !== ref_upper(vec[i])) begin
                errors++;
                $display("FAIL %s[%0d]: out_data=%0d expected %0d", name, i, got_q[i], ref_upper(vec[i]));
            end
        end
        checks++;
        if (char_count !== 16'(vec.size()) || changed_count !== 16'(chg)) begin
            errors++;
            $display("FAIL %s_counters: char=%0d changed=%0d expected %0d %0d",
                     name, char_count, changed_count, vec.size(), chg);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || conv_in !== 8'd0 || char_count !== 16'd0 ||
            changed_count !== 16'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ov=%b od=%0d ci=%0d cc=%0d ch=%0d ir=%b busy=%b expected all 0",
                     out_valid, out_data, conv_in, char_count, changed_count, in_ready, busy);
        end
        do_reset();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        push_byte(8'd97);                 // returns just after E0
        checks++;
        if (conv_in !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_e0: conv_in=%0d busy=%b expected 0 1", conv_in, busy);
        end
        @(posedge clk); #1;               // E1
        checks++;
        if (conv_in !== 8'd97 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e1: conv_in=%0d out_valid=%b expected 97 0", conv_in, out_valid);
        end
        repeat (2) @(posedge clk); #1;    // E3
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_e3: out_valid=%b expected 0", out_valid);
        end
        @(posedge clk); #1;               // E4
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd65 || char_count !== 16'd1 || changed_count !== 16'd1) begin
            errors++;
            $display("FAIL single_e4: ov=%b od=%0d cc=%0d ch=%0d expected 1 65 1 1",
                     out_valid, out_data, char_count, changed_count);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || conv_in !== 8'd97) begin
            errors++;
            $display("FAIL single_after: ov=%b busy=%b conv_in=%0d expected 0 0 97", out_valid, busy, conv_in);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec[$];
        vec = '{8'd72, 8'd122, 8'd123, 8'd64, 8'd109};
        do_reset();
        foreach (vec[i]) push_byte(vec[i]);
        wait_outputs(vec.size());
        check_stream("burst", vec);
        for (int i = 1; i < got_t.size(); i++) begin
            checks++;
            if (got_t[i] - got_t[i-1] != 4) begin
                errors++;
                $display("FAIL burst_spacing[%0d]: gap=%0d expected 4", i, got_t[i] - got_t[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] vec[$];
        vec.delete();
        for (int i = 0; i < 6; i++) vec.push_back(8'($urandom_range(32, 126)));
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(vec[i]);
        in_valid = 1'b1;
        in_data = vec[5];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ref_upper(vec[0]) || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ir=%b ov=%b od=%0d busy=%b expected 0 1 %0d 1",
                         i, in_ready, out_valid, out_data, busy, ref_upper(vec[0]));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        push_byte(vec[5]);
        wait_outputs(6);
        check_stream("bp", vec);
    endtask

    task automatic test_boundaries();
        logic [7:0] vec[$];
        vec = '{8'd96, 8'd97, 8'd122, 8'd123, 8'd183, 8'd0, 8'd255, 8'd65, 8'd90};
        do_reset();
        foreach (vec[i]) push_byte(vec[i]);
        wait_outputs(vec.size());
        check_stream("bound", vec);
    endtask

    task automatic test_random();
        logic [7:0] vec[$];
        bit stop;
        vec.delete();
        for (int i = 0; i < 40; i++) vec.push_back(8'($urandom_range(0, 255)));
        do_reset();
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < vec.size(); i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                    push_byte(vec[i]);
                end
                wait_outputs(vec.size());
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        check_stream("rand", vec);
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_byte(8'd104);                // E0
        push_byte(8'd105);                // E1: first byte popped, now in SETTLE
        push_byte(8'd106);                // E2: two bytes queued
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || conv_in !== 8'd0 || char_count !== 16'd0 ||
            changed_count !== 16'd0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: ov=%b od=%0d ci=%0d cc=%0d ch=%0d ir=%b busy=%b expected all 0",
                     out_valid, out_data, conv_in, char_count, changed_count, in_ready, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midreset_idle[%0d]: out_valid=%b busy=%b expected 0 0", i, out_valid, busy);
            end
        end
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_outputs: got %0d outputs expected 0", got_q.size());
        end
    endtask

    task automatic test_counter_wrap();
        logic [7:0] vec[$];
        int chg;
        vec.delete();
        chg = 0;
        for (int i = 0; i < 17; i++) begin
            vec.push_back(8'($urandom_range(0, 255)));
            if (ref_upper(vec[i]) != vec[i]) chg++;
        end
        do_reset();
        foreach (vec[i]) push_byte(vec[i]);
        wait_outputs(17);
        check_stream("wrap16", vec);
        checks++;
        if (w4_char_count !== 4'd1 || w4_changed_count !== 4'(chg % 16)) begin
            errors++;
            $display("FAIL wrap4_counters: char=%0d changed=%0d expected 1 %0d",
                     w4_char_count, w4_changed_count, chg % 16);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_boundaries();
        test_random();
        test_reset_mid();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
